// File: rtl/meta_pkg.sv
// meta_pkg: shared FSM state type, tdata field offsets and default length for meta_sched
package meta_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int LEN_OFF = 0;
    localparam int DEFAULT_LEN = 1638;
    function automatic int seq_off(input int len_w);
        return LEN_OFF + len_w;
    endfunction
endpackage

// File: rtl/meta_chan.sv
// meta_chan: one metadata channel; counts handshakes and holds tvalid/tdata until accepted (sequence field needs META_SEQ_EN)
module meta_chan
    import meta_pkg::*;
#(
    parameter int DW    = 128,
    parameter int LEN_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] count,
    input  logic             tready,
    output logic             tvalid,
    output logic [DW-1:0]    tdata,
    output logic             fin
);
    logic             hs;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DW-1:0]    beat;
    // handshake accounting; the post-handshake count doubles as the next beat's sequence number
    always_comb begin
        hs    = tvalid & tready;
        cnt_n = cnt + CNT_W'(hs);
        fin   = cnt_n == count;
        beat  = '0;
        beat[LEN_OFF +: LEN_W] = len;
`ifdef META_SEQ_EN
        beat[seq_off(LEN_W) +: CNT_W] = cnt_n;
`endif
    end
    // a pending beat is held until accepted; a new one is raised only while enabled and beats remain
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt    <= '0;
            tvalid <= 1'b0;
            tdata  <= '0;
        end else if (clr) begin
            cnt    <= '0;
        end else begin
            cnt <= cnt_n;
            if (!tvalid || hs) begin
                tvalid <= en && !fin;
                if (en && !fin) tdata <= beat;
            end
        end
    end
endmodule

// File: rtl/meta_sched.sv
// meta_sched: issues cfg_count metadata beats on two independent AXIS channels per run (sequence field needs META_SEQ_EN)
module meta_sched
    import meta_pkg::*;
#(
    parameter int DW    = 128,
    parameter int LEN_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    axis_meta1_tdata,
    output logic             axis_meta1_tvalid,
    input  logic             axis_meta1_tready,
    output logic [DW-1:0]    axis_meta2_tdata,
    output logic             axis_meta2_tvalid,
    input  logic             axis_meta2_tready
);
    state_t           state, nxt;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] count_q;
    logic             start_ok, en, fin1, fin2, drained;
    // next state: normal completion wins over a coincident abort; drain ends once no beat stays pending
    always_comb begin
        nxt      = state;
        start_ok = state == IDLE && start;
        drained  = (!axis_meta1_tvalid || axis_meta1_tready) && (!axis_meta2_tvalid || axis_meta2_tready);
        case (state)
            IDLE:    nxt = start_ok ? RUN : IDLE;
            RUN:     nxt = (fin1 && fin2) ? IDLE : abort ? DRAIN : RUN;
            DRAIN:   nxt = drained ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
        en = state == RUN && nxt == RUN;
    end
    // state register, configuration latch on accepted start, completion pulse on IDLE re-entry
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            done    <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state <= nxt;
            done  <= state != IDLE && nxt == IDLE;
            if (start_ok) begin
                len_q   <= cfg_len;
                count_q <= cfg_count;
            end
        end
    end
    assign busy = state != IDLE;
    meta_chan #(.DW(DW), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_chan1 (
        .clk(clk), .resetn(resetn), .clr(start_ok), .en(en), .len(len_q), .count(count_q),
        .tready(axis_meta1_tready), .tvalid(axis_meta1_tvalid), .tdata(axis_meta1_tdata), .fin(fin1)
    );
    meta_chan #(.DW(DW), .LEN_W(LEN_W), .CNT_W(CNT_W)) u_chan2 (
        .clk(clk), .resetn(resetn), .clr(start_ok), .en(en), .len(len_q), .count(count_q),
        .tready(axis_meta2_tready), .tvalid(axis_meta2_tvalid), .tdata(axis_meta2_tdata), .fin(fin2)
    );
endmodule

// File: tb/tb_meta_sched.sv
// tb_meta_sched: directed self-checking bench for meta_sched (expected sequence field follows META_SEQ_EN)
module tb_meta_sched;
    import meta_pkg::*;
    logic         clk = 1'b0;
    logic         resetn, start, abort, busy, done;
    logic [31:0]  cfg_len;
    logic [15:0]  cfg_count;
    logic [127:0] td1, td2;
    logic         tv1, tv2, tr1, tr2;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    meta_sched dut (
        .clk(clk), .resetn(resetn), .cfg_len(cfg_len), .cfg_count(cfg_count),
        .start(start), .abort(abort), .busy(busy), .done(done),
        .axis_meta1_tdata(td1), .axis_meta1_tvalid(tv1), .axis_meta1_tready(tr1),
        .axis_meta2_tdata(td2), .axis_meta2_tvalid(tv2), .axis_meta2_tready(tr2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat(input logic [31:0] l, input int k);
        logic [127:0] b;
        b = '0;
        b[31:0] = l;
`ifdef META_SEQ_EN
        b[47:32] = k[15:0];
`endif
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input bit v1, input int k1, input bit v2, input int k2, input bit dn);
        check({tag, ".tv1"}, 128'(tv1), 128'(v1));
        if (v1) check({tag, ".td1"}, td1, beat(32'(DEFAULT_LEN), k1));
        check({tag, ".tv2"}, 128'(tv2), 128'(v2));
        if (v2) check({tag, ".td2"}, td2, beat(32'(DEFAULT_LEN), k2));
        check({tag, ".done"}, 128'(done), 128'(dn));
    endtask

    task automatic go(input logic [15:0] cnt);
        cfg_len   = 32'(DEFAULT_LEN);
        cfg_count = cnt;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cfg_len   = 32'd7;
        cfg_count = 16'd9;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; tr1 = 1'b1; tr2 = 1'b1;
        cfg_len = '0; cfg_count = '0;
        tick(); tick();
        check("rst.busy", 128'(busy), 128'd0);
        check("rst.done", 128'(done), 128'd0);
        check("rst.tv", {tv1, tv2}, 128'd0);
        check("rst.td", td1 | td2, 128'd0);
        resetn = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort.busy", 128'(busy), 128'd0);
        check("idle_abort.done", 128'(done), 128'd0);

        go(16'd4);
        check("t1.busy", 128'(busy), 128'd1);
        check("t1.tv_lat", {tv1, tv2}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            step($sformatf("t1.b%0d", k), 1, k, 1, k, 0);
        end
        tick();
        step("t1.end", 0, 0, 0, 0, 1);
        check("t1.busy_end", 128'(busy), 128'd0);
        tick();
        check("t1.done_pulse", 128'(done), 128'd0);

        go(16'd3);
        tick(); step("t2.s1", 1, 0, 1, 0, 0); tr2 = 1'b1;
        tick(); step("t2.s2", 1, 1, 1, 1, 0); tr2 = 1'b0; start = 1'b1;
        tick(); step("t2.s3", 1, 2, 1, 1, 0); tr2 = 1'b1; start = 1'b0;
        tick(); step("t2.s4", 0, 0, 1, 2, 0); tr2 = 1'b0;
        tick(); step("t2.s5", 0, 0, 1, 2, 0); tr2 = 1'b1;
        tick(); step("t2.s6", 0, 0, 0, 0, 1);
        check("t2.busy", 128'(busy), 128'd0);
        tick();
        check("t2.no_restart", 128'(busy), 128'd0);

        go(16'd0);
        check("t3.busy", 128'(busy), 128'd1);
        tick();
        step("t3.end", 0, 0, 0, 0, 1);
        check("t3.busy_end", 128'(busy), 128'd0);
        tick();
        check("t3.done_pulse", 128'(done), 128'd0);

        go(16'd10);
        tick(); step("t4.s1", 1, 0, 1, 0, 0);
        tick(); step("t4.s2", 1, 1, 1, 1, 0);
        tick(); step("t4.s3", 1, 2, 1, 2, 0);
        tr2 = 1'b0; abort = 1'b1;
        tick(); step("t4.s4", 0, 0, 1, 2, 0); abort = 1'b0;
        check("t4.busy", 128'(busy), 128'd1);
        tick(); step("t4.s5", 0, 0, 1, 2, 0); tr2 = 1'b1;
        tick(); step("t4.s6", 0, 0, 0, 0, 1);
        check("t4.busy_end", 128'(busy), 128'd0);
        tick(); step("t4.s7", 0, 0, 0, 0, 0);

        go(16'd5);
        tick(); tick();
        resetn = 1'b0;
        tick();
        check("t5.tv", {tv1, tv2}, 128'd0);
        check("t5.busy", 128'(busy), 128'd0);
        check("t5.td", td1 | td2, 128'd0);
        resetn = 1'b1;
        go(16'd2);
        tick(); step("t6.s1", 1, 0, 1, 0, 0);
        tick(); step("t6.s2", 1, 1, 1, 1, 0);
        tick(); step("t6.s3", 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/meta_sched.md
META_SCHED -- requirements
Module: meta_sched

Interface
REQ-001 Parameter DW, default 128, AXIS metadata tdata width.
REQ-002 Parameter LEN_W, default 32, length field width.
REQ-003 Parameter CNT_W, default 16, beat-count and sequence field width; DW >= LEN_W+CNT_W SHALL hold.
REQ-004 clk  input  1  clock; all logic SHALL be rising-edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 cfg_len  input  LEN_W  length value carried in every metadata beat.
REQ-007 cfg_count  input  CNT_W  beats to issue per channel.
REQ-008 start  input  1  single-cycle request to begin a run.
REQ-009 abort  input  1  stop issuing new beats.
REQ-010 busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-011 done  output  1  one-cycle pulse on run completion or abort completion.
REQ-012 axis_meta1_tdata/tvalid/tready  output/output/input  DW/1/1  channel-1 metadata stream.
REQ-013 axis_meta2_tdata/tvalid/tready  output/output/input  DW/1/1  channel-2 metadata stream.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->IDLE when both channels have issued cfg_count beats; RUN->DRAIN on abort; DRAIN->IDLE when no tvalid remains high.
REQ-015 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-016 cfg_len and cfg_count SHALL be latched on the accepted start; later changes SHALL not affect the run.
REQ-017 Start accepted at edge N: busy and both tvalid SHALL be high after edge N+1 (one-cycle latency).
REQ-018 Beat handshake = tvalid & tready at a rising edge; each channel independent.
REQ-019 Once asserted, tvalid and tdata SHALL remain stable until handshake (AXIS rule), including during DRAIN.
REQ-020 After a handshake with beats remaining, tvalid SHALL stay high with the next beat's tdata (one beat per cycle when tready held high).
REQ-021 Each channel SHALL issue exactly the latched cfg_count beats, then hold tvalid low; a fast channel SHALL not wait for the slow one.
REQ-022 Beat k (k = 0..count-1): tdata[LEN_W-1:0] = latched len; tdata[LEN_W+CNT_W-1:LEN_W] = k (per META_SEQ_EN); remaining upper bits zero.
REQ-023 Sequence counter SHALL wrap modulo 2^CNT_W; cfg_count = 2^CNT_W-1 max.
REQ-024 cfg_count = 0: no tvalid asserted; FSM SHALL go RUN->IDLE and pulse done one cycle after start acceptance.
REQ-025 done SHALL pulse in the cycle IDLE is re-entered from RUN or DRAIN.
REQ-026 abort in IDLE SHALL be ignored; abort in the same cycle as the final handshake SHALL complete as a normal run.
REQ-027 In DRAIN no new beat SHALL be raised; only already-asserted beats complete.

Reset
REQ-028 While resetn = 0 at an edge: state IDLE, busy 0, done 0, both tvalid 0, both tdata 0, counters 0.
REQ-029 Reset mid-run SHALL abandon in-flight beats immediately (sole permitted tvalid drop without handshake).

Configuration
REQ-030 Macro META_SEQ_EN defined: sequence field driven per REQ-022.
REQ-031 META_SEQ_EN undefined: sequence field SHALL be zero and sequence counters SHALL not be built; beat counting unchanged.

Structure
REQ-032 Package meta_pkg SHALL hold the FSM state enum, field offset constants, and DEFAULT_LEN = 1638.
REQ-033 Per-channel issue logic (counter, tvalid/tdata hold) SHALL be sub-module meta_chan, instantiated twice.

Verification
REQ-034 len=1638, count=4, both tready=1 -> each channel 4 beats in consecutive cycles, seq 0..3, low word 1638, done 5 cycles after start edge.
REQ-035 count=3, tready1=1, tready2 toggling 1/0 -> ch1 finishes in 3 cycles, ch2 tdata stable while stalled, done after ch2's third beat.
REQ-036 count=0 -> no tvalid, done pulse one cycle after start, busy low again.
REQ-037 count=10, abort after 2 handshakes with tready2=0 -> ch2 beat held until tready2=1, no further beats, done then IDLE.
REQ-038 resetn=0 mid-run -> next cycle all tvalid 0, busy 0; start afterward runs from seq 0.
REQ-039 Build without META_SEQ_EN, count=2 -> tdata = 1638 zero-extended on every beat.
